// File: rtl/triple_arbiter.sv
// Round-robin arbiter that time-shares one multiply-by-3 datapath among four requesters.
// Each operation takes four cycles: grant, two accumulate steps, result.
module triple_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*W-1:0]         ops,
    output logic [N_REQ-1:0]           gnt,
    output logic [W+1:0]               res,
    output logic [$clog2(N_REQ)-1:0]   res_id,
    output logic                       res_valid,
    output logic                       busy
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ADD0, ADD1, DONE} state_t;

    state_t          state;
    logic [W-1:0]    op_reg;
    logic [W+1:0]    acc;
    logic [IW-1:0]   idx_reg;
    logic [IW-1:0]   last_grant;

    logic            found;
    logic [IW-1:0]   win;
    logic [IW-1:0]   probe;
    logic [W+1:0]    sum;

    // Search begins one past the previous winner and wraps.
    always_comb begin
        found = 1'b0;
        win   = '0;
        probe = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            probe = last_grant + IW'(k) + IW'(1);
            if (!found && req[probe]) begin
                found = 1'b1;
                win   = probe;
            end
        end
    end

    assign sum = acc + {1'b0, op_reg, 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            res        <= '0;
            res_id     <= '0;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
            acc        <= '0;
            op_reg     <= '0;
            idx_reg    <= '0;
            last_grant <= IW'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    gnt <= '0;
                    if (found) begin
                        gnt        <= N_REQ'(1) << win;
                        op_reg     <= ops[win*W +: W];
                        idx_reg    <= win;
                        last_grant <= win;
                        busy       <= 1'b1;
                        state      <= ADD0;
                    end
                end
                ADD0: begin
                    gnt   <= '0;
                    acc   <= {2'b00, op_reg};
                    state <= ADD1;
                end
                // Result registered on entry to DONE so res_valid is high for the DONE cycle itself.
                ADD1: begin
                    acc       <= sum;
                    res       <= sum;
                    res_id    <= idx_reg;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/triple_arbiter.md
TRIPLE_ARBITER -- requirements
Module: triple_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters; fixed at 4 for this block.
REQ-002 Parameter: W, 8, operand width; result width is W+2 (255*3 = 765 fits in 10 bits).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  4  req[i] high = requester i has an operand pending; held until granted.
REQ-006 ops  input  32  packed operands; requester i operand at ops[8i+7:8i].
REQ-007 gnt  output  4  one-hot, one-cycle pulse; operand of granted requester captured.
REQ-008 res  output  10  registered result = captured operand * 3.
REQ-009 res_id  output  2  index of requester owning res.
REQ-010 res_valid  output  1  one-cycle pulse; res and res_id valid.
REQ-011 busy  output  1  high whenever FSM is not in IDLE.

Function
REQ-012 The block SHALL time-share a single multiply-by-3 datapath among 4 requesters using a 4-state FSM: IDLE, ADD0, ADD1, DONE.
REQ-013 IDLE: if any req bit high at a posedge, the block SHALL select one winner, capture its operand and index, set gnt to the winner one-hot, and go to ADD0; otherwise stay IDLE with gnt = 0.
REQ-014 Arbitration SHALL be round-robin: search starts at (last_grant + 1) mod 4, wrapping; last_grant updates only on a grant.
REQ-015 ADD0: acc <= {2'b00, op_reg}; gnt SHALL return to 0; go to ADD1.
REQ-016 ADD1: acc <= acc + {1'b0, op_reg, 1'b0}; go to DONE; sum computed at 10 bits, no truncation.
REQ-017 DONE: res <= acc, res_id <= captured index, res_valid high for exactly this cycle; go to IDLE.
REQ-018 Latency: gnt high during the cycle after the sampling edge; res_valid high during the 3rd cycle after it. Throughput: one operation per 4 cycles.
REQ-019 Grants SHALL be issued only from IDLE; req changes in ADD0/ADD1/DONE SHALL NOT affect the operation in progress.
REQ-020 Operand changes after the capture edge SHALL NOT affect res.
REQ-021 A requester still asserting req after its result SHALL be treated as a new request, subject to round-robin.
REQ-022 res and res_id SHALL hold their last values between res_valid pulses.
REQ-023 busy SHALL equal (state != IDLE).

Reset
REQ-024 While rst is high: state = IDLE; gnt, res, res_id, res_valid, busy, acc, op_reg = 0; last_grant = 3 so requester 0 has first priority.
REQ-025 Reset asserted mid-operation SHALL abort it immediately; no res_valid pulse for the aborted operation.
REQ-026 After rst deasserts, the first sampling edge SHALL be the first posedge with rst low.

Verification
REQ-027 Reset: rst=1 with random req/ops -> all outputs 0, busy=0.
REQ-028 Single request: req=0010, op1=85 -> gnt=0010 for 1 cycle, then res=255, res_id=1, res_valid for 1 cycle, 3 cycles after the sampling edge.
REQ-029 Max operand: req=0001, op0=255 -> res=765; op0=0 -> res=0.
REQ-030 Contention: req=1111 held, ops=4,3,2,1 (op0..op3) -> grants 0,1,2,3 in that order, 4 cycles apart; results 12,9,6,3 with matching res_id.
REQ-031 Round-robin wrap: after a grant to 2, req=1001 -> grant 3, then grant 0.
REQ-032 Reset mid-op: rst pulsed during ADD1 of a requester-2 operation -> no res_valid; next req=0101 -> grant to 0.
